module_cpu_control: RTL and testbench
=====================================

MODULE_CPU_CONTROL -- requirements
Module: module_cpu_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8: maximum cycles spent waiting for an ALU handshake.
REQ-002 SHALL have parameter CNT_W, default 8: width of the completed-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-005 SHALL have port power, input, 1 bit: level-sensitive on/off switch.
REQ-006 SHALL have port send, input, 1 bit: one-cycle pulse from the debounced button that submits an instruction.
REQ-007 SHALL have port instr, input, 16 bits: {opcode[15:13], dest[12:10], src1[9:7], field[6:0]}; field is {sinal, Imm[5:0]} for immediate ops, or {src2[6:4], 4'b0} for ADD/SUB.
REQ-008 SHALL have ports decoded and calculated, inputs, 1 bit each: handshakes from the ALU.
REQ-009 SHALL have port lcd_done, input, 1 bit: one-cycle pulse when the display refresh has finished.
REQ-010 SHALL have port stateCPU, output, 3 bits, with encoding OFF=000, FETCH=001, DECODE=010, READ=011, CALC=100, SHOW=101, STORE=110.
REQ-011 SHALL have outputs opcode (3 bits), sinalImm (1 bit) and Imm (6 bits): ALU operand fields taken from the instruction register (IR).
REQ-012 SHALL have outputs rd_addr1 and rd_addr2, 3 bits each: register-file read addresses (src1 and src2 from IR).
REQ-013 SHALL have outputs wr_en (1 bit) and wr_addr (3 bits): register-file write strobe and destination address.
REQ-014 SHALL have output clear_all, 1 bit: one-cycle strobe that zeroes every register.
REQ-015 SHALL have outputs lcd_start (1 bit), err (1 bit) and instr_count (CNT_W bits).

Function
REQ-016 SHALL hold stateCPU=OFF while power=0; power=0 SHALL force OFF on the next edge from any state, abandoning the instruction with no write and no clear.
REQ-017 SHALL go OFF->FETCH on the first edge with power=1.
REQ-018 SHALL, in FETCH, wait for send; on send, latch instr into IR, clear err, and go to DECODE; send in any other state SHALL be ignored.
REQ-019 SHALL, in DECODE, wait for decoded=1 and then go to READ on the next edge.
REQ-020 SHALL remain in READ for exactly 1 cycle (synchronous register-file read latency), then go to CALC.
REQ-021 SHALL, in CALC, wait for calculated=1; next state SHALL be SHOW for DISPLAY (111) and STORE for all other opcodes.
REQ-022 SHALL spend exactly 1 cycle in STORE, then go to SHOW.
- During STORE, wr_en=1 with wr_addr=dest for LOAD, ADD, ADDI, SUB, SUBI and MUL.
- For CLEAR, clear_all=1 and wr_en=0.
REQ-023 SHALL pulse lcd_start high for exactly the first cycle of SHOW, wait for lcd_done, then go to FETCH and increment instr_count.
REQ-024 SHALL wrap instr_count from 2^CNT_W-1 to 0.
REQ-025 SHALL count cycles spent in DECODE or CALC without the awaited handshake; on reaching TIMEOUT it SHALL go to FETCH, set err=1 (sticky until the next accepted send), skip STORE/SHOW and leave instr_count unchanged.
REQ-026 SHALL give the handshake priority when the handshake arrives in the same cycle the counter reaches TIMEOUT.
REQ-027 SHALL drive opcode, sinalImm, Imm, rd_addr1, rd_addr2 and wr_addr from IR, held stable from DECODE through SHOW.
REQ-028 SHALL keep wr_en, clear_all and lcd_start low in all states except those given above; they are mutually exclusive.
REQ-029 SHALL apply priority rst > power=0 > normal transitions.

Reset
REQ-030 SHALL, on rst=1 at an edge, set stateCPU=OFF, IR=0, instr_count=0, err=0, timeout counter=0, and wr_en=clear_all=lcd_start=0, regardless of state; power is re-evaluated on the first edge after rst falls.
REQ-031 SHALL give every output a defined value after the first clocked reset (no X).

Verification
REQ-032 SHALL cover ADDI: power=1, send with instr={010,011,001,0,000101}, decoded after 1 cycle, calculated after 1 cycle -> states FETCH,DECODE,READ,CALC,STORE,SHOW; wr_en one cycle with wr_addr=3; Imm=5, sinalImm=0; instr_count 0->1.
REQ-033 SHALL cover DISPLAY and CLEAR: DISPLAY (111) -> CALC goes directly to SHOW with no wr_en; CLEAR (110) -> clear_all for one cycle, wr_en=0.
REQ-034 SHALL cover timeout: decoded held 0 -> after 8 cycles in DECODE, state=FETCH, err=1, no wr_en/lcd_start; the next send clears err.
REQ-035 SHALL cover power drop: power=0 during CALC -> stateCPU=OFF next edge, no write; power=1 -> FETCH.
REQ-036 SHALL cover counter wrap and reset: 256 completed instructions -> instr_count=0; rst asserted in STORE -> next edge OFF with all strobes 0.
REQ-037 SHALL cover ignored send: send pulses during CALC and SHOW -> IR unchanged and no extra instruction executed.

Source files
------------

// File: rtl/module_cpu_control.sv
// Instruction sequencer for a small CPU: fetches a button-submitted instruction,
// walks it through decode/read/calc/store/show with ALU and LCD handshakes.
module module_cpu_control #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             power,
    input  logic             send,
    input  logic [15:0]      instr,
    input  logic             decoded,
    input  logic             calculated,
    input  logic             lcd_done,
    output logic [2:0]       stateCPU,
    output logic [2:0]       opcode,
    output logic             sinalImm,
    output logic [5:0]       Imm,
    output logic [2:0]       rd_addr1,
    output logic [2:0]       rd_addr2,
    output logic             wr_en,
    output logic [2:0]       wr_addr,
    output logic             clear_all,
    output logic             lcd_start,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef enum logic [2:0] {
        S_OFF    = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_READ   = 3'b011,
        S_CALC   = 3'b100,
        S_SHOW   = 3'b101,
        S_STORE  = 3'b110
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_ir;
    logic [15:0]      w_ir_next;
    logic             r_err;
    logic             w_err_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [TW-1:0]    r_tmo;
    logic [TW-1:0]    w_tmo_next;
    logic             r_show_first;
    logic             w_show_first_next;
    logic             w_tmo_hit;
    logic             w_is_store;
    logic             w_unused_lsbs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_OFF;
            r_ir         <= '0;
            r_err        <= 1'b0;
            r_count      <= '0;
            r_tmo        <= '0;
            r_show_first <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ir         <= w_ir_next;
            r_err        <= w_err_next;
            r_count      <= w_count_next;
            r_tmo        <= w_tmo_next;
            r_show_first <= w_show_first_next;
        end
    end

    // r_tmo counts handshake-less cycles already spent; the handshake is tested first
    // so it wins on the very cycle the limit is hit.
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_next      = r_state;
        w_ir_next         = r_ir;
        w_err_next        = r_err;
        w_count_next      = r_count;
        w_tmo_next        = r_tmo;
        w_show_first_next = 1'b0;
        if (!power) begin
            w_state_next = S_OFF;
            w_tmo_next   = '0;
        end else begin
            case (r_state)
                S_OFF: w_state_next = S_FETCH;
                S_FETCH: begin
                    if (send) begin
                        w_ir_next    = instr;
                        w_err_next   = 1'b0;
                        w_tmo_next   = '0;
                        w_state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (decoded) begin
                        w_tmo_next   = '0;
                        w_state_next = S_READ;
                    end else if (w_tmo_hit) begin
                        w_tmo_next   = '0;
                        w_err_next   = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_tmo_next = r_tmo + 1'b1;
                    end
                end
                S_READ: begin
                    w_tmo_next   = '0;
                    w_state_next = S_CALC;
                end
                S_CALC: begin
                    if (calculated) begin
                        w_tmo_next = '0;
                        if (r_ir[15:13] == OP_DISPLAY) begin
                            w_state_next      = S_SHOW;
                            w_show_first_next = 1'b1;
                        end else begin
                            w_state_next = S_STORE;
                        end
                    end else if (w_tmo_hit) begin
                        w_tmo_next   = '0;
                        w_err_next   = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_tmo_next = r_tmo + 1'b1;
                    end
                end
                S_STORE: begin
                    w_state_next      = S_SHOW;
                    w_show_first_next = 1'b1;
                end
                S_SHOW: begin
                    if (lcd_done) begin
                        w_count_next = r_count + 1'b1;
                        w_state_next = S_FETCH;
                    end
                end
                default: w_state_next = S_OFF;
            endcase
        end
    end

    assign stateCPU    = r_state;
    assign opcode      = r_ir[15:13];
    assign wr_addr     = r_ir[12:10];
    assign rd_addr1    = r_ir[9:7];
    assign rd_addr2    = r_ir[6:4];
    assign sinalImm    = r_ir[6];
    assign Imm         = r_ir[5:0];
    assign err         = r_err;
    assign instr_count = r_count;

    // Strobes are gated by power so a switch-off in STORE never commits a write.
    assign w_is_store = (r_state == S_STORE) && power;
    assign wr_en      = w_is_store && (opcode != OP_CLEAR) && (opcode != OP_DISPLAY);
    assign clear_all  = w_is_store && (opcode == OP_CLEAR);
    assign lcd_start  = (r_state == S_SHOW) && r_show_first && power;

    assign w_unused_lsbs = ^r_ir[3:0];
endmodule

// File: tb/tb_module_cpu_control.sv
// Self-checking bench for module_cpu_control: table-driven ADDI walk, hand-written
// corner sequences, and a strobe scoreboard fed at submit time and drained by a monitor.
module tb_module_cpu_control;
    localparam int TMO = 8;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          power = 1'b0;
    logic          send = 1'b0;
    logic [15:0]   instr = '0;
    logic          decoded = 1'b0;
    logic          calculated = 1'b0;
    logic          lcd_done = 1'b0;
    logic [2:0]    stateCPU;
    logic [2:0]    opcode;
    logic          sinalImm;
    logic [5:0]    Imm;
    logic [2:0]    rd_addr1;
    logic [2:0]    rd_addr2;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic          clear_all;
    logic          lcd_start;
    logic          err;
    logic [CW-1:0] instr_count;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [CW-1:0] exp_count = '0;
    logic [2:0]    wr_q[$];
    int            exp_clr = 0;
    int            exp_lcd = 0;

    localparam logic [2:0] ST_OFF = 3'b000, ST_FETCH = 3'b001, ST_DECODE = 3'b010,
                           ST_READ = 3'b011, ST_CALC = 3'b100, ST_SHOW = 3'b101,
                           ST_STORE = 3'b110;

    typedef struct {
        logic          power;
        logic          send;
        logic          dec;
        logic          calc;
        logic          done;
        logic [15:0]   ins;
        logic [2:0]    st;
        logic          wr;
        logic          clr;
        logic          lcd;
        logic          er;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vt[10];
    vec_t exp_q[$];

    module_cpu_control #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .power(power), .send(send), .instr(instr),
        .decoded(decoded), .calculated(calculated), .lcd_done(lcd_done),
        .stateCPU(stateCPU), .opcode(opcode), .sinalImm(sinalImm), .Imm(Imm),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_en(wr_en), .wr_addr(wr_addr),
        .clear_all(clear_all), .lcd_start(lcd_start), .err(err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe monitor: every write/clear/lcd strobe must match an expectation queued at submit.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d expected no write", wr_addr);
            end else begin
                chk("write_addr", wr_addr, wr_q.pop_front());
            end
        end
        if (clear_all === 1'b1) begin
            n_checks++;
            if (exp_clr == 0) begin
                n_fail++;
                $display("FAIL unexpected_clear: got clear_all=1 expected 0");
            end else exp_clr--;
        end
        if (lcd_start === 1'b1) begin
            n_checks++;
            if (exp_lcd == 0) begin
                n_fail++;
                $display("FAIL unexpected_lcd_start: got lcd_start=1 expected 0");
            end else exp_lcd--;
        end
        if ((wr_en === 1'b1) || (clear_all === 1'b1) || (lcd_start === 1'b1))
            chk("strobe_exclusive", $countones({wr_en, clear_all, lcd_start}), 1);
    end

    // Submits one instruction; dw/cw are handshake-less cycles in DECODE/CALC (>= TMO times out).
    task automatic do_instr(input logic [15:0] ins, input int dw, input int cw, input bit noisy);
        logic [2:0]    op;
        logic [CW-1:0] cnt0;
        bit            timed_out;
        op        = ins[15:13];
        cnt0      = exp_count;
        timed_out = 1'b0;
        if ((dw < TMO) && (cw < TMO)) begin
            if ((op != 3'b110) && (op != 3'b111)) wr_q.push_back(ins[12:10]);
            if (op == 3'b110) exp_clr++;
            exp_lcd++;
        end
        instr = ins;
        send  = 1'b1;
        step();
        send  = 1'b0;
        instr = 16'h0;
        chk("decode_entry", stateCPU, ST_DECODE);
        chk("err_cleared", err, 0);
        chk("ir_opcode", opcode, op);
        for (int i = 0; i < TMO; i++) begin
            if (i < dw) begin
                step();
                if (i == TMO - 1) timed_out = 1'b1;
                else chk("decode_wait", stateCPU, ST_DECODE);
            end else begin
                decoded = 1'b1;
                step();
                decoded = 1'b0;
                chk("read_state", stateCPU, ST_READ);
                break;
            end
        end
        if (!timed_out) begin
            step();
            chk("calc_entry", stateCPU, ST_CALC);
            if (noisy) instr = 16'hFFFF;
            for (int i = 0; i < TMO; i++) begin
                send = noisy && (i == 0);
                if (i < cw) begin
                    step();
                    send = 1'b0;
                    if (i == TMO - 1) timed_out = 1'b1;
                    else chk("calc_wait", stateCPU, ST_CALC);
                end else begin
                    calculated = 1'b1;
                    step();
                    calculated = 1'b0;
                    send = 1'b0;
                    if (op == 3'b111) begin
                        chk("display_to_show", stateCPU, ST_SHOW);
                    end else begin
                        chk("store_state", stateCPU, ST_STORE);
                        chk("store_wr_en", wr_en, (op != 3'b110));
                        chk("store_clear", clear_all, (op == 3'b110));
                        step();
                        chk("show_state", stateCPU, ST_SHOW);
                    end
                    break;
                end
            end
        end
        if (timed_out) begin
            chk("timeout_state", stateCPU, ST_FETCH);
            chk("timeout_err", err, 1);
            chk("timeout_count", instr_count, cnt0);
        end else begin
            chk("lcd_start_first", lcd_start, 1);
            send = noisy;
            step();
            send = 1'b0;
            chk("show_hold", stateCPU, ST_SHOW);
            chk("lcd_start_once", lcd_start, 0);
            lcd_done = 1'b1;
            step();
            lcd_done = 1'b0;
            exp_count = exp_count + 1'b1;
            chk("back_to_fetch", stateCPU, ST_FETCH);
            chk("instr_count", instr_count, exp_count);
            chk("ir_held_opcode", opcode, op);
            chk("ir_held_dest", wr_addr, ins[12:10]);
            chk("ir_held_imm", Imm, ins[5:0]);
        end
        instr = 16'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t e;
        logic [15:0] rins;
        // power, send, dec, calc, done, instr, state, wr, clr, lcd, err, count
        vt[0] = '{1, 0, 0, 0, 0, 16'h0000, ST_FETCH,  0, 0, 0, 0, 8'd0};
        vt[1] = '{1, 1, 0, 0, 0, 16'h4C85, ST_DECODE, 0, 0, 0, 0, 8'd0};
        vt[2] = '{1, 0, 0, 0, 0, 16'h0000, ST_DECODE, 0, 0, 0, 0, 8'd0};
        vt[3] = '{1, 0, 1, 0, 0, 16'h0000, ST_READ,   0, 0, 0, 0, 8'd0};
        vt[4] = '{1, 0, 0, 0, 0, 16'h0000, ST_CALC,   0, 0, 0, 0, 8'd0};
        vt[5] = '{1, 0, 0, 0, 0, 16'h0000, ST_CALC,   0, 0, 0, 0, 8'd0};
        vt[6] = '{1, 0, 0, 1, 0, 16'h0000, ST_STORE,  1, 0, 0, 0, 8'd0};
        vt[7] = '{1, 0, 0, 0, 0, 16'h0000, ST_SHOW,   0, 0, 1, 0, 8'd0};
        vt[8] = '{1, 0, 0, 0, 0, 16'h0000, ST_SHOW,   0, 0, 0, 0, 8'd0};
        vt[9] = '{1, 0, 0, 0, 1, 16'h0000, ST_FETCH,  0, 0, 0, 0, 8'd1};

        // Reset wins over power=1; then power=0 holds OFF.
        power = 1'b1;
        step();
        step();
        chk("rst_state", stateCPU, ST_OFF);
        chk("rst_count", instr_count, 0);
        chk("rst_err", err, 0);
        chk("rst_strobes", {wr_en, clear_all, lcd_start}, 0);
        chk("rst_ir", {opcode, sinalImm, Imm, rd_addr1, rd_addr2, wr_addr}, 0);
        rst   = 1'b0;
        power = 1'b0;
        step();
        chk("power_off_hold", stateCPU, ST_OFF);

        // ADDI walk from the vector table.
        wr_q.push_back(3'd3);
        exp_lcd++;
        for (int k = 0; k < 10; k++) begin
            power = vt[k].power; send = vt[k].send; decoded = vt[k].dec;
            calculated = vt[k].calc; lcd_done = vt[k].done; instr = vt[k].ins;
            exp_q.push_back(vt[k]);
            step();
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_state", k), stateCPU, e.st);
            chk($sformatf("vec%0d_wr_en", k), wr_en, e.wr);
            chk($sformatf("vec%0d_clear", k), clear_all, e.clr);
            chk($sformatf("vec%0d_lcd", k), lcd_start, e.lcd);
            chk($sformatf("vec%0d_err", k), err, e.er);
            chk($sformatf("vec%0d_count", k), instr_count, e.cnt);
            if (k == 6) chk("vec6_wr_addr", wr_addr, 3);
        end
        send = 1'b0; decoded = 1'b0; calculated = 1'b0; lcd_done = 1'b0;
        exp_count = 8'd1;
        chk("addi_imm", Imm, 6'd5);
        chk("addi_sinal", sinalImm, 0);
        chk("addi_opcode", opcode, 3'b010);
        chk("addi_src1", rd_addr1, 3'd1);

        do_instr({3'b111, 3'd0, 3'd2, 7'd0}, 1, 1, 1'b0);        // DISPLAY
        do_instr({3'b110, 3'd5, 3'd0, 7'd0}, 0, 0, 1'b0);        // CLEAR
        do_instr({3'b001, 3'd4, 3'd1, 3'd2, 4'd0}, TMO, 0, 1'b0); // decode timeout
        do_instr({3'b011, 3'd2, 3'd3, 1'b1, 6'd9}, 0, 0, 1'b0);  // send clears err
        do_instr({3'b100, 3'd1, 3'd1, 1'b0, 6'd3}, 0, TMO, 1'b0); // calc timeout
        do_instr({3'b000, 3'd7, 3'd6, 1'b0, 6'd33}, TMO - 1, TMO - 1, 1'b0); // handshake at limit
        do_instr({3'b101, 3'd6, 3'd5, 3'd4, 4'd0}, 1, 2, 1'b1);  // sends in CALC/SHOW ignored

        // Power drop in CALC abandons the instruction.
        instr = {3'b001, 3'd5, 3'd1, 3'd2, 4'd0};
        send  = 1'b1;
        step();
        send  = 1'b0;
        chk("pwr_decode", stateCPU, ST_DECODE);
        decoded = 1'b1;
        step();
        decoded = 1'b0;
        step();
        chk("pwr_calc", stateCPU, ST_CALC);
        power = 1'b0;
        step();
        chk("pwr_drop_off", stateCPU, ST_OFF);
        chk("pwr_drop_wr", wr_en, 0);
        power = 1'b1;
        step();
        chk("pwr_restore_fetch", stateCPU, ST_FETCH);
        chk("pwr_count", instr_count, exp_count);

        // Run until the completed-instruction counter wraps to zero.
        while (exp_count != '0) begin
            rins = 16'($urandom());
            do_instr(rins, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end
        chk("count_wrap", instr_count, 0);

        // Reset asserted while in STORE.
        instr = {3'b011, 3'd6, 3'd2, 1'b0, 6'd1};
        wr_q.push_back(3'd6);
        send = 1'b1;
        step();
        send = 1'b0;
        decoded = 1'b1;
        step();
        decoded = 1'b0;
        step();
        calculated = 1'b1;
        step();
        calculated = 1'b0;
        chk("rst_store_state", stateCPU, ST_STORE);
        rst = 1'b1;
        step();
        chk("rst_in_store_off", stateCPU, ST_OFF);
        chk("rst_in_store_strobes", {wr_en, clear_all, lcd_start}, 0);
        chk("rst_in_store_ir", opcode, 0);
        rst = 1'b0;
        exp_count = '0;
        step();
        chk("after_rst_fetch", stateCPU, ST_FETCH);
        chk("after_rst_count", instr_count, exp_count);
        step();

        chk("wr_queue_drained", wr_q.size(), 0);
        chk("clr_expect_drained", exp_clr, 0);
        chk("lcd_expect_drained", exp_lcd, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
